// File: rtl/seq_dect_pkg.sv
// ============================================================================
// Module      : seq_dect_pkg
// Description : Shared definitions for the 01110 sequence-detector slice.
//               Holds the controller defaults, the controller FSM encoding,
//               the detector state encoding and the detector single-bit
//               step function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_dect_pkg;

    // Default geometry: 8 symbol pairs per word, 4-bit match counter.
    localparam int NPAIR_DEF = 8;
    localparam int CNTW_DEF  = 4;

    // Controller FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_t;

    // Detector state = longest prefix of 01110 seen at the end of the stream.
    typedef enum logic [2:0] {
        DS_NONE = 3'd0,
        DS_0    = 3'd1,
        DS_01   = 3'd2,
        DS_011  = 3'd3,
        DS_0111 = 3'd4
    } det_state_t;

    typedef struct packed {
        logic       hit;
        det_state_t nxt;
    } det_step_t;

    // Advance the detector by one serial bit. After a hit the trailing 0 is
    // itself a valid prefix, so overlapping occurrences are counted.
    function automatic det_step_t det_step(input det_state_t s, input logic x);
        det_step_t r;
        r.hit = 1'b0;
        r.nxt = DS_NONE;
        case (s)
            DS_NONE: begin
                if (x) r.nxt = DS_NONE;
                else   r.nxt = DS_0;
            end
            DS_0: begin
                if (x) r.nxt = DS_01;
                else   r.nxt = DS_0;
            end
            DS_01: begin
                if (x) r.nxt = DS_011;
                else   r.nxt = DS_0;
            end
            DS_011: begin
                if (x) r.nxt = DS_0111;
                else   r.nxt = DS_0;
            end
            DS_0111: begin
                if (x) begin
                    r.nxt = DS_NONE;
                end else begin
                    r.hit = 1'b1;
                    r.nxt = DS_0;
                end
            end
            default: r.nxt = DS_NONE;
        endcase
        return r;
    endfunction

endpackage : seq_dect_pkg

`default_nettype wire

// File: rtl/seq_dect.sv
// ============================================================================
// Module      : seq_dect
// Description : Serial 01110 pattern detector. Consumes one symbol pair per
//               clock, A first then B. o_z is combinational and flags a
//               pattern completing on either bit of the current pair.
// Ports       : clk      - clock, rising edge
//               i_clr_n  - asynchronous active-low clear (state -> no prefix)
//               i_a/i_b  - first/second serial bit of the pair
//               o_z      - hit in the current pair
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_dect
    import seq_dect_pkg::*;
(
    input  logic clk,
    input  logic i_clr_n,
    input  logic i_a,
    input  logic i_b,
    output logic o_z
);

    det_state_t r_state;
    det_step_t  w_step_a;
    det_step_t  w_step_b;

    always_comb begin
        w_step_a = det_step(r_state, i_a);
        w_step_b = det_step(w_step_a.nxt, i_b);
    end

    // A pattern is 5 bits long and cannot recur with period 1, so at most one
    // of the two bits in a pair can complete a hit.
    assign o_z = w_step_a.hit | w_step_b.hit;

    always_ff @(posedge clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state <= DS_NONE;
        end else begin
            r_state <= w_step_b.nxt;
        end
    end

endmodule : seq_dect

`default_nettype wire

// File: rtl/seq_dect_ctrl.sv
// ============================================================================
// Module      : seq_dect_ctrl
// Description : Word-level controller around seq_dect. Accepts a word of
//               NPAIR symbol pairs, scans min(in_len, NPAIR) pairs one per
//               cycle, and reports hit count, found flag and first hit index.
// Ports       : clk, clr (sync active-high reset)
//               in_valid/in_ready/in_data/in_len  - word input handshake
//               out_valid/out_ready               - result handshake
//               match_cnt/found/first_pos         - result fields
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_dect_ctrl
    import seq_dect_pkg::*;
#(
    parameter int NPAIR = NPAIR_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*NPAIR-1:0]        in_data,
    input  logic [CNTW-1:0]           in_len,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNTW-1:0]           match_cnt,
    output logic                      found,
    output logic [$clog2(NPAIR)-1:0]  first_pos
);

    localparam int POSW = $clog2(NPAIR);
    localparam logic [CNTW-1:0] C_NPAIR = CNTW'(NPAIR);

    ctrl_state_t         r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [2*NPAIR-1:0]  r_data;
    logic [CNTW-1:0]     r_len;
    logic [CNTW-1:0]     r_k;
    logic [CNTW-1:0]     r_match_cnt;
    logic                r_found;
    logic [POSW-1:0]     r_first_pos;
    logic                r_det_clr_n;

    logic [CNTW-1:0]     w_eff_len;
    logic                w_run;
    logic                w_a;
    logic                w_b;
    logic                w_z;

    assign w_eff_len = (in_len > C_NPAIR) ? C_NPAIR : in_len;
    assign w_run     = (r_state == ST_RUN);

    // The word is shifted left each RUN cycle, so pair k is always on top.
    // Outside RUN the detector sees 11, which never advances toward a match.
    assign w_a = w_run ? r_data[2*NPAIR-1] : 1'b1;
    assign w_b = w_run ? r_data[2*NPAIR-2] : 1'b1;

    seq_dect u_det (
        .clk     (clk),
        .i_clr_n (r_det_clr_n),
        .i_a     (w_a),
        .i_b     (w_b),
        .o_z     (w_z)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_len       <= '0;
            r_k         <= '0;
            r_match_cnt <= '0;
            r_found     <= 1'b0;
            r_first_pos <= '0;
            r_det_clr_n <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_data      <= in_data;
                        r_len       <= w_eff_len;
                        r_k         <= '0;
                        r_match_cnt <= '0;
                        r_found     <= 1'b0;
                        r_first_pos <= '0;
                        r_in_ready  <= 1'b0;
                        if (w_eff_len == '0) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= ST_RUN;
                            r_det_clr_n <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    r_data <= r_data << 2;
                    r_k    <= r_k + CNTW'(1);
                    if (w_z) begin
                        r_match_cnt <= r_match_cnt + CNTW'(1);
                        r_found     <= 1'b1;
                        if (r_match_cnt == '0) begin
                            r_first_pos <= r_k[POSW-1:0];
                        end
                    end
                    if (r_k == r_len - CNTW'(1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_det_clr_n <= 1'b0;
                    end
                end

                ST_DONE: begin
                    // in_ready rises only after this edge, so no word can be
                    // taken in the cycle a result is consumed.
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_det_clr_n <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign match_cnt = r_match_cnt;
    assign found     = r_found;
    assign first_pos = r_first_pos;

endmodule : seq_dect_ctrl

`default_nettype wire

// File: tb/tb_seq_dect_ctrl.sv
// ============================================================================
// Module      : tb_seq_dect_ctrl
// Description : Self-checking bench for seq_dect_ctrl: directed vector table,
//               reset/abort sequences and random words against a bit-string
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_dect_ctrl;

    localparam int NP = 8;
    localparam int CW = 4;

    logic            clk;
    logic            clr;
    logic            in_valid;
    logic            in_ready;
    logic [2*NP-1:0] in_data;
    logic [CW-1:0]   in_len;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   match_cnt;
    logic            found;
    logic [2:0]      first_pos;

    int n_pass;
    int n_total;

    seq_dect_ctrl #(.NPAIR(NP), .CNTW(CW)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .match_cnt (match_cnt),
        .found     (found),
        .first_pos (first_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  len;
        int          hold;
        int          e_cnt;
        int          e_found;
        int          e_pos;
        int          e_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: unroll the scanned pairs into a bit string and look for
    // 01110 windows; a window ending on bit j belongs to pair j/2.
    task automatic model(input logic [15:0] d, input int len,
                         output int cnt, output int pos, output int lat);
        int eff;
        logic b[16];
        eff = (len > NP) ? NP : len;
        for (int j = 0; j < 16; j++) b[j] = d[15-j];
        cnt = 0;
        pos = 0;
        for (int j = 4; j < 2*eff; j++) begin
            if (!b[j-4] && b[j-3] && b[j-2] && b[j-1] && !b[j]) begin
                if (cnt == 0) pos = j / 2;
                cnt++;
            end
        end
        lat = eff + 1;
    endtask

    task automatic run_word(input logic [15:0] d, input logic [3:0] len,
                            input int hold, input int e_cnt, input int e_found,
                            input int e_pos, input int e_lat, input string tag);
        int n;
        @(negedge clk);
        check({tag, " in_ready_before"}, int'(in_ready), 1);
        in_data  = d;
        in_len   = len;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            if (in_ready) check({tag, " in_ready_busy"}, int'(in_ready), 0);
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, e_lat);
        check({tag, " match_cnt"}, int'(match_cnt), e_cnt);
        check({tag, " found"}, int'(found), e_found);
        check({tag, " first_pos"}, int'(first_pos), e_pos);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, " hold_valid"}, int'(out_valid), 1);
            check({tag, " hold_ready"}, int'(in_ready), 0);
            check({tag, " hold_cnt"}, int'(match_cnt), e_cnt);
            check({tag, " hold_pos"}, int'(first_pos), e_pos);
        end
        // Offer a word in the consume cycle; it must not be taken.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h7000;
        in_len    = 4'd8;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, " consumed_valid"}, int'(out_valid), 0);
        check({tag, " idle_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int c, p, l, hits;
        logic [15:0] rd;
        logic [3:0]  rl;

        n_pass    = 0;
        n_total   = 0;
        clr       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        out_ready = 1'b0;

        vecs[0] = '{16'h7000, 4'd8,  0, 1, 1, 2, 9};
        vecs[1] = '{16'h7380, 4'd8,  0, 2, 1, 2, 9};
        vecs[2] = '{16'hFFFF, 4'd8,  0, 0, 0, 0, 9};
        vecs[3] = '{16'h7000, 4'd2,  0, 0, 0, 0, 3};
        vecs[4] = '{16'h7000, 4'd0,  0, 0, 0, 0, 1};
        vecs[5] = '{16'h7000, 4'd15, 0, 1, 1, 2, 9};
        vecs[6] = '{16'h0007, 4'd8,  0, 0, 0, 0, 9};
        vecs[7] = '{16'h0000, 4'd8,  5, 0, 0, 0, 9};

        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        check("rst in_ready", int'(in_ready), 1);
        check("rst out_valid", int'(out_valid), 0);
        check("rst match_cnt", int'(match_cnt), 0);
        check("rst found", int'(found), 0);
        check("rst first_pos", int'(first_pos), 0);

        for (int i = 0; i < 8; i++) begin
            run_word(vecs[i].data, vecs[i].len, vecs[i].hold, vecs[i].e_cnt,
                     vecs[i].e_found, vecs[i].e_pos, vecs[i].e_lat,
                     $sformatf("vec%0d", i));
        end

        // Abort 16'h7380 with clr in its fourth RUN cycle.
        @(negedge clk);
        in_data  = 16'h7380;
        in_len   = 4'd8;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) hits++;
            @(posedge clk);
            #1;
        end
        check("abort out_valid_seen", hits, 0);
        check("abort in_ready", int'(in_ready), 1);
        run_word(16'h7000, 4'd8, 0, 1, 1, 2, 9, "after_abort");

        // Random words; every fourth word is seeded with the pattern.
        for (int i = 0; i < 30; i++) begin
            rd = 16'($urandom);
            if (i % 4 == 0) rd[13:9] = 5'b01110;
            rl = 4'($urandom_range(0, 15));
            model(rd, int'(rl), c, p, l);
            run_word(rd, rl, int'($urandom_range(0, 2)), c, (c != 0) ? 1 : 0,
                     p, l, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_seq_dect_ctrl

`default_nettype wire
